// File: rtl/write_iq.sv
// write_iq: pops I/Q fixed-point pairs, dequantizes and saturates each sample
// to a signed CHAR_SIZE value, and serializes each pair as four
// little-endian bytes (I lo, I hi, Q lo, Q hi) into a byte FIFO.
module write_iq #(
  parameter int DATA_SIZE = 32,
  parameter int BYTE_SIZE = 8,
  parameter int CHAR_SIZE = 16,
  parameter int BITS      = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] i_in_dout,
  input  logic                 i_in_empty,
  output logic                 i_in_rd_en,
  input  logic [DATA_SIZE-1:0] q_in_dout,
  input  logic                 q_in_empty,
  output logic                 q_in_rd_en,
  input  logic                 out_full,
  output logic                 out_wr_en,
  output logic [BYTE_SIZE-1:0] out_din,
  output logic [15:0]          sat_count
);

  typedef enum logic [2:0] {S_IDLE, S_B0, S_B1, S_B2, S_B3} state_t;

  localparam logic signed [DATA_SIZE-1:0] SMAX = DATA_SIZE'((2 ** (CHAR_SIZE - 1)) - 1);
  localparam logic signed [DATA_SIZE-1:0] SMIN = ~SMAX;

  state_t               r_state;
  state_t               w_state_next;
  logic [CHAR_SIZE-1:0] r_i_samp;
  logic [CHAR_SIZE-1:0] r_q_samp;
  logic [15:0]          r_sat_count;
  logic                 w_pop;
  logic                 w_pop_fire;
  logic [CHAR_SIZE:0]   w_i_res;
  logic [CHAR_SIZE:0]   w_q_res;
  logic [16:0]          w_sat_sum;

  // Returns {clipped, value}: arithmetic shift then clip to the signed range.
  function automatic logic [CHAR_SIZE:0] dq_sat(input logic [DATA_SIZE-1:0] w);
    logic signed [DATA_SIZE-1:0] d;
    d = $signed(w) >>> BITS;
    if (d > SMAX)      dq_sat = {1'b1, SMAX[CHAR_SIZE-1:0]};
    else if (d < SMIN) dq_sat = {1'b1, SMIN[CHAR_SIZE-1:0]};
    else               dq_sat = {1'b0, d[CHAR_SIZE-1:0]};
  endfunction

  assign w_pop      = ~i_in_empty & ~q_in_empty;
  assign w_i_res    = dq_sat(i_in_dout);
  assign w_q_res    = dq_sat(q_in_dout);
  assign w_sat_sum  = {1'b0, r_sat_count} + 17'(w_i_res[CHAR_SIZE]) + 17'(w_q_res[CHAR_SIZE]);
  assign i_in_rd_en = w_pop_fire;
  assign q_in_rd_en = w_pop_fire;
  assign sat_count  = r_sat_count;

  // Next-state, pop strobe and byte output decode.
  always_comb begin
    w_state_next = r_state;
    w_pop_fire   = 1'b0;
    out_wr_en    = 1'b0;
    out_din      = '0;
    case (r_state)
      S_IDLE: begin
        if (w_pop) begin
          w_pop_fire   = 1'b1;
          w_state_next = S_B0;
        end
      end
      S_B0: begin
        out_din = r_i_samp[BYTE_SIZE-1:0];
        if (!out_full) begin
          out_wr_en    = 1'b1;
          w_state_next = S_B1;
        end
      end
      S_B1: begin
        out_din = r_i_samp[CHAR_SIZE-1:BYTE_SIZE];
        if (!out_full) begin
          out_wr_en    = 1'b1;
          w_state_next = S_B2;
        end
      end
      S_B2: begin
        out_din = r_q_samp[BYTE_SIZE-1:0];
        if (!out_full) begin
          out_wr_en    = 1'b1;
          w_state_next = S_B3;
        end
      end
      S_B3: begin
        // The next pop overlaps the last byte write to sustain 4 cycles/pair.
        out_din = r_q_samp[CHAR_SIZE-1:BYTE_SIZE];
        if (!out_full) begin
          out_wr_en = 1'b1;
          if (w_pop) begin
            w_pop_fire   = 1'b1;
            w_state_next = S_B0;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    // Reset holds all strobes and data low so nothing is popped or written.
    if (reset) begin
      w_pop_fire = 1'b0;
      out_wr_en  = 1'b0;
      out_din    = '0;
    end
  end

  // State, sample registers and saturating clip counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_i_samp    <= '0;
      r_q_samp    <= '0;
      r_sat_count <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_pop_fire) begin
        r_i_samp    <= w_i_res[CHAR_SIZE-1:0];
        r_q_samp    <= w_q_res[CHAR_SIZE-1:0];
        r_sat_count <= w_sat_sum[16] ? '1 : w_sat_sum[15:0];
      end
    end
  end

endmodule

// File: tb/tb_write_iq.sv
// Scoreboard bench for write_iq: stimulus pushes words into modelled FIFOs and
// expected bytes into a queue; a monitor compares every written byte.
module tb_write_iq;

  localparam int DATA_SIZE = 32;
  localparam int BYTE_SIZE = 8;
  localparam int CHAR_SIZE = 16;
  localparam int BITS      = 10;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [DATA_SIZE-1:0] i_in_dout;
  logic                 i_in_empty;
  logic                 i_in_rd_en;
  logic [DATA_SIZE-1:0] q_in_dout;
  logic                 q_in_empty;
  logic                 q_in_rd_en;
  logic                 out_full;
  logic                 out_wr_en;
  logic [BYTE_SIZE-1:0] out_din;
  logic [15:0]          sat_count;

  write_iq #(.DATA_SIZE(DATA_SIZE), .BYTE_SIZE(BYTE_SIZE),
             .CHAR_SIZE(CHAR_SIZE), .BITS(BITS)) dut (
    .clock(clock), .reset(reset),
    .i_in_dout(i_in_dout), .i_in_empty(i_in_empty), .i_in_rd_en(i_in_rd_en),
    .q_in_dout(q_in_dout), .q_in_empty(q_in_empty), .q_in_rd_en(q_in_rd_en),
    .out_full(out_full), .out_wr_en(out_wr_en), .out_din(out_din),
    .sat_count(sat_count)
  );

  always #5 clock = ~clock;

  logic [31:0] iq_fifo[$];
  logic [31:0] qq_fifo[$];
  logic [7:0]  exp_bytes[$];
  int unsigned sat_pend[$];
  int          pop_cyc[$];
  int          wr_cyc[$];
  int unsigned exp_sat = 0;
  int          cyc = 0;
  bit          full_force = 1'b0;
  bit          rand_full  = 1'b0;
  int          nchk = 0;
  int          nfail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: floor division by 2^BITS, then clip to the signed 16-bit range.
  function automatic void model(input logic [31:0] w, output logic [15:0] v, output int clip);
    longint x, d, div;
    x    = longint'($signed(w));
    div  = longint'(1) << BITS;
    d    = x / div;
    if (x < 0 && (x % div) != 0) d = d - 1;
    clip = 0;
    if (d > 32767)       begin d = 32767;  clip = 1; end
    else if (d < -32768) begin d = -32768; clip = 1; end
    v = 16'(d);
  endfunction

  task automatic push_expect(input logic [31:0] i, input logic [31:0] q);
    logic [15:0] vi, vq;
    int ci, cq;
    model(i, vi, ci);
    model(q, vq, cq);
    exp_bytes.push_back(vi[7:0]);
    exp_bytes.push_back(vi[15:8]);
    exp_bytes.push_back(vq[7:0]);
    exp_bytes.push_back(vq[15:8]);
    sat_pend.push_back(ci + cq);
  endtask

  task automatic push_pair(input logic [31:0] i, input logic [31:0] q);
    iq_fifo.push_back(i);
    qq_fifo.push_back(q);
    push_expect(i, q);
  endtask

  task automatic drain(input string name);
    int k;
    for (k = 0; k < 400; k++) begin
      if (exp_bytes.size() == 0 && iq_fifo.size() == 0 && qq_fifo.size() == 0) break;
      @(posedge clock);
    end
    chk({name, "_drain_left"}, 64'(exp_bytes.size()), 64'd0);
    repeat (2) @(posedge clock);
  endtask

  task automatic wait_writes(input string name, input int target);
    int k;
    for (k = 0; k < 100; k++) begin
      if (wr_cyc.size() >= target) break;
      @(posedge clock);
    end
    chk({name, "_wait_writes"}, 64'(wr_cyc.size() >= target), 64'd1);
  endtask

  // Monitor: drive FIFO heads and full at negedge, sample settled outputs after.
  always @(negedge clock) begin
    i_in_empty = (iq_fifo.size() == 0);
    q_in_empty = (qq_fifo.size() == 0);
    i_in_dout  = i_in_empty ? '0 : iq_fifo[0];
    q_in_dout  = q_in_empty ? '0 : qq_fifo[0];
    out_full   = full_force || (rand_full && ($urandom_range(0, 9) < 3));
    #2;
    cyc++;
    chk("sat_count", 64'(sat_count), 64'(exp_sat));
    chk("rd_en_pair", 64'(i_in_rd_en), 64'(q_in_rd_en));
    if (i_in_rd_en) begin
      chk("pop_nonempty", {62'd0, i_in_empty, q_in_empty}, 64'd0);
      if (!i_in_empty && !q_in_empty) begin
        void'(iq_fifo.pop_front());
        void'(qq_fifo.pop_front());
        if (sat_pend.size() > 0) begin
          exp_sat = exp_sat + sat_pend.pop_front();
          if (exp_sat > 65535) exp_sat = 65535;
        end
      end
      pop_cyc.push_back(cyc);
    end
    if (out_wr_en) begin
      chk("wr_not_full", 64'(out_full), 64'd0);
      if (exp_bytes.size() == 0) chk("unexpected_byte", 64'(out_din), 64'hx);
      else chk("byte", 64'(out_din), 64'(exp_bytes.pop_front()));
      wr_cyc.push_back(cyc);
    end
    if (reset) begin
      exp_bytes.delete();
      exp_sat = 0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail + 1);
    $fatal(1, "watchdog");
  end

  logic [31:0] edge_vals[10] = '{32'h01FFFC00, 32'h01FFFFFF, 32'h02000000, 32'hFE000000,
                                 32'hFDFFFFFF, 32'h000003FF, 32'hFFFFFFFF, 32'hFFFFFC00,
                                 32'h7FFFFFFF, 32'h80000000};

  initial begin : stim
    int pb, wb;
    logic [31:0] a, b;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_rd_en", {62'd0, i_in_rd_en, q_in_rd_en}, 64'd0);
    chk("rst_wr_en", 64'(out_wr_en), 64'd0);
    chk("rst_din", 64'(out_din), 64'd0);
    chk("rst_sat", 64'(sat_count), 64'd0);
    reset = 1'b0;
    @(posedge clock);

    // Nominal pair, latency T+1..T+4
    pb = pop_cyc.size(); wb = wr_cyc.size();
    push_pair(32'h0048D000, 32'hFFFBF800);
    drain("t1");
    chk("t1_npop", 64'(pop_cyc.size() - pb), 64'd1);
    chk("t1_nwr", 64'(wr_cyc.size() - wb), 64'd4);
    if (pop_cyc.size() > pb && wr_cyc.size() >= wb + 4)
      for (int k = 0; k < 4; k++) chk("t1_latency", 64'(wr_cyc[wb + k] - pop_cyc[pb]), 64'(k + 1));
    chk("t1_sat", 64'(sat_count), 64'd0);

    // Both samples saturate
    push_pair(32'h7FFFFFFF, 32'h80000000);
    drain("t2");
    chk("t2_sat", 64'(sat_count), 64'd2);

    // Output full for 3 cycles while in S_B1
    wb = wr_cyc.size();
    push_pair(32'h00000C00, 32'hFFFFFBFF);
    wait_writes("t3", wb + 1);
    #1 full_force = 1'b1;
    repeat (3) @(posedge clock);
    #1 full_force = 1'b0;
    drain("t3");
    if (wr_cyc.size() >= wb + 4) begin
      chk("t3_stall_gap", 64'(wr_cyc[wb + 1] - wr_cyc[wb]), 64'd4);
      chk("t3_tail_gap", 64'(wr_cyc[wb + 3] - wr_cyc[wb + 1]), 64'd2);
    end else chk("t3_nwr", 64'(wr_cyc.size() - wb), 64'd4);

    // Three preloaded pairs stream back to back
    pb = pop_cyc.size(); wb = wr_cyc.size();
    push_pair(32'h00012345, 32'hFFF00000);
    push_pair(32'h00400000, 32'hFFC00000);
    push_pair(32'h12345678, 32'h00000000);
    drain("t4");
    chk("t4_npop", 64'(pop_cyc.size() - pb), 64'd3);
    chk("t4_nwr", 64'(wr_cyc.size() - wb), 64'd12);
    if (pop_cyc.size() >= pb + 3 && wr_cyc.size() >= wb + 12) begin
      chk("t4_pop1", 64'(pop_cyc[pb + 1] - pop_cyc[pb]), 64'd4);
      chk("t4_pop2", 64'(pop_cyc[pb + 2] - pop_cyc[pb]), 64'd8);
      for (int k = 0; k < 12; k++) chk("t4_wr_cycle", 64'(wr_cyc[wb + k] - pop_cyc[pb]), 64'(k + 1));
    end

    // I available, Q empty: nothing happens until Q arrives
    pb = pop_cyc.size(); wb = wr_cyc.size();
    iq_fifo.push_back(32'h00001400);
    repeat (10) @(posedge clock);
    chk("t5_nopop", 64'(pop_cyc.size() - pb), 64'd0);
    chk("t5_nowr", 64'(wr_cyc.size() - wb), 64'd0);
    qq_fifo.push_back(32'hFFFFEC00);
    push_expect(32'h00001400, 32'hFFFFEC00);
    drain("t5");
    chk("t5_npop", 64'(pop_cyc.size() - pb), 64'd1);

    // Reset after two bytes of a pair
    wb = wr_cyc.size();
    push_pair(32'h7FFFFFFF, 32'h00ABCD00);
    wait_writes("t6", wb + 2);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    chk("t6_nwr", 64'(wr_cyc.size() - wb), 64'd2);
    chk("t6_rd_en", {62'd0, i_in_rd_en, q_in_rd_en}, 64'd0);
    chk("t6_wr_en", 64'(out_wr_en), 64'd0);
    chk("t6_din", 64'(out_din), 64'd0);
    chk("t6_sat", 64'(sat_count), 64'd0);
    wb = wr_cyc.size();
    push_pair(32'h00002800, 32'h00003C00);
    drain("t6b");
    chk("t6b_nwr", 64'(wr_cyc.size() - wb), 64'd4);

    // Boundary values
    for (int k = 0; k < 10; k++) push_pair(edge_vals[k], edge_vals[9 - k]);
    drain("edge");

    // Randomized traffic with random backpressure
    rand_full = 1'b1;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 2))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = 32'($urandom_range(0, 32'h03FFFFFF)) - 32'h02000000;
                 b = 32'($urandom_range(0, 32'h03FFFFFF)) - 32'h02000000; end
        default: begin a = edge_vals[$urandom_range(0, 9)]; b = $urandom; end
      endcase
      push_pair(a, b);
      repeat ($urandom_range(0, 5)) @(posedge clock);
    end
    drain("rand");
    rand_full = 1'b0;
    drain("final");
    chk("final_fifos_empty", 64'(iq_fifo.size() + qq_fifo.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
